inst_mem_pl: RTL and testbench

INST_MEM_PL -- requirements
Module: inst_mem_pl

---
 rtl/inst_mem_pl.sv | 84 ++++++++
 tb/tb_inst_mem_pl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pl.sv
// Pipelined instruction memory: word-addressed storage with a program-load port and a
// LATENCY-deep fetch pipeline that returns NOP_WORD with a fault flag for bad addresses.
module inst_mem_pl #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 256,
    parameter int                 ADDR_W   = 10,
    parameter int                 LATENCY  = 1,
    parameter logic [DATA_W-1:0]  NOP_WORD = 32'h00000013,
    localparam int                IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [LATENCY-1:0] stg_valid;
    logic [LATENCY-1:0] stg_fault;
    logic [DATA_W-1:0]  stg_word [LATENCY];

    logic              advance;
    logic              accept;
    logic [ADDR_W-3:0] widx;
    logic              out_of_range;
    logic              fault;
    logic [DATA_W-1:0] rd_word;

    // Pipeline-advance, handshake and fault decode for the incoming request.
    always_comb begin
        advance      = !stg_valid[LATENCY-1] || rsp_ready;
        req_ready    = !ld_en && advance;
        accept       = req_valid && req_ready;
        widx         = req_addr[ADDR_W-1:2];
        // Extra leading zero keeps DEPTH representable even when it fills the index range.
        out_of_range = ({1'b0, widx} >= (ADDR_W-1)'(DEPTH));
        fault        = (req_addr[1:0] != 2'b00) || out_of_range;
        if (accept && !fault) begin
            rd_word = mem[widx[IDX_W-1:0]];
        end else begin
            rd_word = NOP_WORD;
        end
    end

    // Program-load write port; storage is intentionally untouched by reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Fetch pipeline: every stage moves together, bubbles carry NOP_WORD so outputs need no mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            stg_fault <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg_word[i] <= NOP_WORD;
            end
        end else if (advance) begin
            stg_valid[0] <= accept;
            stg_fault[0] <= accept && fault;
            stg_word[0]  <= rd_word;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_fault[i] <= stg_fault[i-1];
                stg_word[i]  <= stg_word[i-1];
            end
        end
    end

    assign rsp_valid = stg_valid[LATENCY-1];
    assign rsp_fault = stg_fault[LATENCY-1];
    assign rsp_data  = stg_word[LATENCY-1];

endmodule

// File: tb/tb_inst_mem_pl.sv
// Directed bench for inst_mem_pl: one LATENCY=1 and one LATENCY=2 instance share the
// request and load stimulus, each with its own response-ready control.
module tb_inst_mem_pl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [11:0] req_addr;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    logic        rdy1, req_ready1, rsp_valid1, rsp_fault1;
    logic [31:0] rsp_data1;
    logic        rdy2, req_ready2, rsp_valid2, rsp_fault2;
    logic [31:0] rsp_data2;

    int checks;
    int errors;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h00100093;
    localparam logic [31:0] W1  = 32'h00500113;
    localparam logic [31:0] W2  = 32'h00A00193;
    localparam logic [31:0] WB  = 32'hDEADBEEF;

    inst_mem_pl #(.DATA_W(32), .DEPTH(256), .ADDR_W(12), .LATENCY(1), .NOP_WORD(32'h00000013)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready1), .req_addr(req_addr),
        .rsp_valid(rsp_valid1), .rsp_ready(rdy1), .rsp_data(rsp_data1), .rsp_fault(rsp_fault1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_pl #(.DATA_W(32), .DEPTH(256), .ADDR_W(12), .LATENCY(2), .NOP_WORD(32'h00000013)) u2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready2), .req_addr(req_addr),
        .rsp_valid(rsp_valid2), .rsp_ready(rdy2), .rsp_data(rsp_data2), .rsp_fault(rsp_fault2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp1(input string tag, input logic v, input logic [31:0] d, input logic f);
        chk({tag, "_v1"}, {31'd0, rsp_valid1}, {31'd0, v});
        chk({tag, "_d1"}, rsp_data1, d);
        chk({tag, "_f1"}, {31'd0, rsp_fault1}, {31'd0, f});
    endtask

    task automatic chk_rsp2(input string tag, input logic v, input logic [31:0] d, input logic f);
        chk({tag, "_v2"}, {31'd0, rsp_valid2}, {31'd0, v});
        chk({tag, "_d2"}, rsp_data2, d);
        chk({tag, "_f2"}, {31'd0, rsp_fault2}, {31'd0, f});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 12'h000;
        ld_en     = 1'b0;
        ld_addr   = 8'd0;
        ld_data   = 32'h0;
        rdy1      = 1'b1;
        rdy2      = 1'b1;

        #1;
        chk_rsp1("reset", 1'b0, NOP, 1'b0);
        chk_rsp2("reset", 1'b0, NOP, 1'b0);
        #11;
        rst = 1'b0;

        // Program load
        ld_en = 1'b1; ld_addr = 8'd0; ld_data = W0;
        step();
        ld_addr = 8'd1; ld_data = W1;
        step();
        ld_addr = 8'd2; ld_data = W2;
        step();
        ld_en = 1'b0;

        // Back-to-back fetches and faults, LATENCY=1
        req_valid = 1'b1; req_addr = 12'h000;
        #1;
        chk("ready1_idle", {31'd0, req_ready1}, 32'd1);
        step();
        chk_rsp1("fetch0", 1'b1, W0, 1'b0);
        req_addr = 12'h004;
        step();
        chk_rsp1("fetch4", 1'b1, W1, 1'b0);
        req_addr = 12'h006;
        step();
        chk_rsp1("misalign", 1'b1, NOP, 1'b1);
        req_addr = 12'h400;
        step();
        chk_rsp1("range", 1'b1, NOP, 1'b1);
        req_valid = 1'b0;
        step();
        chk_rsp1("idle", 1'b0, NOP, 1'b0);
        step();
        chk_rsp2("drained", 1'b0, NOP, 1'b0);

        // Stall with LATENCY=2
        req_valid = 1'b1; req_addr = 12'h000;
        step();
        chk("l2_lat_v", {31'd0, rsp_valid2}, 32'd0);
        req_addr = 12'h004;
        step();
        chk_rsp2("l2_first", 1'b1, W0, 1'b0);
        req_addr = 12'h008;
        rdy2 = 1'b0;
        #1;
        chk("l2_stall_rdy", {31'd0, req_ready2}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_rsp2("l2_hold", 1'b1, W0, 1'b0);
            chk("l2_hold_rdy", {31'd0, req_ready2}, 32'd0);
        end
        rdy2 = 1'b1;
        #1;
        chk("l2_resume_rdy", {31'd0, req_ready2}, 32'd1);
        step();
        chk_rsp2("l2_second", 1'b1, W1, 1'b0);
        req_valid = 1'b0;
        step();
        chk_rsp2("l2_third", 1'b1, W2, 1'b0);
        step();
        chk_rsp2("l2_empty", 1'b0, NOP, 1'b0);

        // Load beats fetch, then read-after-load
        ld_en = 1'b1; ld_addr = 8'd5; ld_data = WB;
        req_valid = 1'b1; req_addr = 12'h014;
        #1;
        chk("ld_block_rdy", {31'd0, req_ready1}, 32'd0);
        step();
        chk_rsp1("ld_noaccept", 1'b0, NOP, 1'b0);
        ld_en = 1'b0;
        step();
        chk_rsp1("raw", 1'b1, WB, 1'b0);
        req_valid = 1'b0;
        step();
        step();

        // Reset with fetches in flight
        req_valid = 1'b1; req_addr = 12'h000;
        step();
        req_addr = 12'h004;
        step();
        chk("pre_rst_v2", {31'd0, rsp_valid2}, 32'd1);
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_rsp2("async_rst", 1'b0, NOP, 1'b0);
        chk_rsp1("async_rst", 1'b0, NOP, 1'b0);
        step();
        rst = 1'b0;
        req_valid = 1'b1; req_addr = 12'h000;
        #1;
        chk("post_rst_rdy", {31'd0, req_ready2}, 32'd1);
        step();
        chk("post_rst_drop", {31'd0, rsp_valid2}, 32'd0);
        chk_rsp1("post_rst", 1'b1, W0, 1'b0);
        req_valid = 1'b0;
        step();
        chk_rsp2("post_rst", 1'b1, W0, 1'b0);
        step();
        chk_rsp2("post_rst_end", 1'b0, NOP, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
